// File: rtl/input_word_loader_pkg.sv
// input_pkg: shared types and helpers for the input word loader and the
// other front-panel blocks.
//   loader_state_t : lane FSM states (FILL = collecting bytes, HOLD = word
//                    waiting for the consumer)
//   lane_bits()    : width of a lane index for a given word width, never
//                    less than 1 bit
package input_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

    function automatic int lane_bits(int width);
        int lanes;
        lanes = width / 8;
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/input_word_loader_if.sv
// input_word_loader_if: valid/ready word channel from the loader to its
// consumer (CPU / memory loader).
//   out_valid : producer -> consumer, completed word available
//   out_ready : consumer -> producer, consumer accepts out_data
//   out_data  : producer -> consumer, WIDTH-bit word, lane 0 in bits [7:0]
// master = producer side, slave = consumer side.
interface input_word_loader_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/input_word_loader_key_debounce.sv
// key_debounce: conditions one raw, asynchronous, active-low push key.
// A 2-flop synchroniser feeds a debouncer that only accepts a new level
// after it has been stable for DB_CYCLES consecutive cycles. A single-cycle
// registered pulse is emitted when the accepted level falls (key pressed);
// release produces nothing, so a held key gives exactly one press.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   key_n  : raw key, pressed = 0
//   press  : one-cycle pulse, the cycle after the debounced level falls
module key_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    // Synchroniser and stable level reset to "released" so a key held
    // through reset is still seen as one fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                lvl   <= s2;
                cnt   <= '0;
                press <= ~s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_word_loader.sv
// input_word_loader: assembles a WIDTH-bit word from the 8 switches, one
// byte lane per debounced key press, and hands the finished word to a
// consumer over a valid/ready channel.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high
//   sw       : byte value committed on a press
//   commit_n : raw active-low commit key
//   out_bus  : master side of the word channel (out_valid/out_ready/out_data)
//   word     : word under assembly (HEX display)
//   lane     : next lane to be written
//   led      : current contents of lane `lane` of `word` (combinational)
module input_word_loader
    import input_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    sw,
    input  logic                          commit_n,
    input_word_loader_if.master           out_bus,
    output logic [WIDTH-1:0]              word,
    output logic [lane_bits(WIDTH)-1:0]   lane,
    output logic [7:0]                    led
);

    localparam int unsigned LANES = WIDTH / 8;
    localparam int unsigned LW    = lane_bits(WIDTH);

    loader_state_t    state;
    logic             press;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_commit_key (
        .clk   (clk),
        .reset (reset),
        .key_n (commit_n),
        .press (press)
    );

    // Word with the switch byte merged into the current lane; the final
    // lane's byte must appear in out_data on the same edge it is written.
    always_comb begin
        next_word = word;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane == LW'(i)) begin
                next_word[i*8 +: 8] = sw;
            end
        end
    end

    always_comb begin
        led = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane == LW'(i)) begin
                led = word[i*8 +: 8];
            end
        end
    end

    // In HOLD the handshake wins and any press is dropped, so out_data
    // stays frozen until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            lane        <= '0;
            word        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (press) begin
                        word <= next_word;
                        if (lane == LW'(LANES - 1)) begin
                            out_data_q  <= next_word;
                            out_valid_q <= 1'b1;
                            lane        <= '0;
                            state       <= HOLD;
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        word        <= '0;
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign out_bus.out_valid = out_valid_q;
    assign out_bus.out_data  = out_data_q;

endmodule
